// File: rtl/owm_counter.sv
// Purpose: parameterised up-counter with enable, sync clear and a registered "advanced" flag (one-wire timebase).
// Latency: 1 cycle; cnt/out reflect the inputs sampled at the preceding rising edge.
// Backpressure: none; ena gates advance, clr overrides ena. Define COUNTER_SATURATE_EN to saturate instead of wrap.
module owm_counter #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          out
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          out_q;
   logic          out_d;

`ifdef COUNTER_SATURATE_EN
   // All-ones value at which the counter parks instead of wrapping.
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
`endif

   // Next-state: clear beats enable; out flags that cnt advanced on this edge.
   always_comb begin
      cnt_d = cnt_q;
      out_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         out_d = 1'b0;
      end else if (ena) begin
`ifdef COUNTER_SATURATE_EN
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            out_d = 1'b1;
         end else begin
            // Parked at the top: no advance, so status reports idle.
            cnt_d = cnt_q;
            out_d = 1'b0;
         end
`else
         // Modulo wrap; out stays high across the rollover since cnt still moved.
         cnt_d = cnt_q + 1'b1;
         out_d = 1'b1;
`endif
      end
   end

   // State registers with synchronous active-low reset taking top priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign cnt = cnt_q;
   assign out = out_q;

endmodule

// File: tb/tb_owm_counter.sv
// Directed bench for owm_counter with CW = 3; expectations follow the wrap or saturate build.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
// Every scenario begins with a two-cycle reset.
module tb_owm_counter;

   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          ena;
   logic          clr;
   logic [CW-1:0] cnt;
   logic          out;

   int tests_run;
   int tests_failed;

   owm_counter #(.CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .clr (clr),
      .cnt (cnt),
      .out (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bound the run in case something stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int observed, input int expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Apply one set of inputs for one rising edge, then settle past the edge.
   task automatic step(input logic r, input logic c, input logic e);
      @(negedge clk);
      rst = r;
      clr = c;
      ena = e;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input int exp_cnt, input int exp_out);
      check({tag, " cnt"}, int'(cnt), exp_cnt);
      check({tag, " out"}, int'(out), exp_out);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b0;
      clr = 1'b0;
      ena = 1'b0;

      // Reset: two edges low, then two idle edges high.
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 1'b0);
         expect_state("reset", 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0);
         expect_state("idle_after_reset", 0, 0);
      end

      // Count and wrap: 1..7 then 0 (or 7 with out low when saturating).
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
         if (i < 7) expect_state("count_sat", i + 1, 1);
         else       expect_state("count_sat_top", 7, 0);
`else
         expect_state("count_wrap", (i + 1) % 8, 1);
`endif
      end

      // Clear priority over enable for 4 cycles, then count 8 more.
      do_reset();
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      expect_state("pre_clear", 2, 1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1);
         expect_state("clear_hold", 0, 0);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b1);
`ifdef COUNTER_SATURATE_EN
         if (i < 7) expect_state("after_clear_sat", i + 1, 1);
         else       expect_state("after_clear_sat_top", 7, 0);
`else
         expect_state("after_clear", (i + 1) % 8, 1);
`endif
      end

      // Hold at 5 for 3 cycles, then resume to 6.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
      expect_state("reach_5", 5, 1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         expect_state("hold", 5, 0);
      end
      step(1'b1, 1'b0, 1'b1);
      expect_state("resume", 6, 1);

      // Mid-count reset at 4, then restart from 0.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
      expect_state("reach_4", 4, 1);
      step(1'b0, 1'b0, 1'b1);
      expect_state("mid_reset", 0, 0);
      step(1'b1, 1'b0, 1'b1);
      expect_state("post_reset", 1, 1);

      // Simultaneous events: reset beats clear and enable; clear beats enable.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      expect_state("reach_3", 3, 1);
      step(1'b0, 1'b1, 1'b1);
      expect_state("rst_clr_ena", 0, 0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      expect_state("reach_2", 2, 1);
      step(1'b1, 1'b1, 1'b1);
      expect_state("clr_ena", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
